// File: rtl/rr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arb_pkg                                                |
// | Brief    : Shared constants, state encoding and helpers for the      |
// |            round-robin 8:1 mux arbiter.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package rr_arb_pkg;

  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 8;

  // Code 2'd3 is unused; the sequencer treats it as a return to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux8_arbiter_pick8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_pick8                                                  |
// | Brief    : Combinational circular-priority picker. Returns the first |
// |            requester at or after ptr (mod 8).                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]   w_enc;

  // Rotate so that req[ptr] lands at bit 0; bit k of w_rot is req[(ptr+k) mod 8].
  always_comb begin
    w_dbl = {req, req} >> ptr;
    w_rot = w_dbl[N_REQ-1:0];
  end

  // Fixed priority encoder on the rotated vector (lowest bit wins), then undo the rotation.
  always_comb begin
    w_enc = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_enc = SEL_W'(k);
      end
    end
    any = |req;
    idx = w_enc + ptr;
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux8_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_mux8_arbiter                                           |
// | Brief    : Round-robin arbiter/sequencer sharing an 8:1 single-bit   |
// |            mux. Bursts are capped at MAX_HOLD cycles (0 = no cap)    |
// |            and every grant is followed by one turnaround cycle so    |
// |            the mux select never moves mid-transfer.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_mux8_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             s2,
  output logic             s1,
  output logic             s0
);

  localparam logic [HOLD_W-1:0] C_MAX_HOLD = HOLD_W'(MAX_HOLD);
  localparam logic              C_LIMITED  = (MAX_HOLD != 0);

  state_t            r_state;
  logic [N_REQ-1:0]  r_gnt;
  logic              r_valid;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;

  logic              w_any;
  logic [SEL_W-1:0]  w_idx;
  logic              w_release;

  rr_pick8 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // A burst ends when its owner drops the request or the hold cap is reached;
  // both together still produce a single release.
  always_comb begin
    w_release = ~req[r_sel] | (C_LIMITED & (r_hold == C_MAX_HOLD));
  end

  // Sequencer: IDLE arbitrates, GRANT holds the mux, TURN inserts the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en && w_any) begin
            r_gnt   <= idx_to_onehot(w_idx);
            r_valid <= 1'b1;
            r_sel   <= w_idx;
            r_hold  <= HOLD_W'(1);
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= r_sel + 3'd1;
            r_hold  <= '0;
            r_state <= TURN;
          end else if (r_hold != '1) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        TURN: begin
          // Select lines keep their last value; arbitration resumes in IDLE.
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_hold  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    gnt       = r_gnt;
    gnt_valid = r_valid;
    s2        = r_sel[2];
    s1        = r_sel[1];
    s0        = r_sel[0];
  end

endmodule
`default_nettype wire

// File: doc/rr_mux8_arbiter.md
Name: rr_mux8_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the team's 8:1 single-bit mux (in0..in7, select s2 s1 s0) between 8 requesters.
- Grants one requester at a time and drives the mux select lines.
- Limits each grant to a burst of MAX_HOLD cycles.
- Inserts one turnaround cycle between grants, so the mux output is never switched mid-transfer.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles per requester. Legal range 0..255. 0 = unlimited (grant is held until the requester drops its request).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  when low, no new grant is issued. A grant already in progress runs to completion.
- req  input  8  request vector; req[i] is held high by requester i for its whole transfer.
- gnt  output  8  one-hot grant, registered; all zeros when idle.
- gnt_valid  output  1  high when gnt is non-zero.
- s2  output  1  mux select MSB, registered; together with s1 and s0 forms sel = {s2,s1,s0} = index of the granted requester.
- s1  output  1  mux select bit 1.
- s0  output  1  mux select LSB.

Behaviour:
- Reset (rst high at a clock edge) produces: gnt=0, gnt_valid=0, {s2,s1,s0}=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset overrides everything, including a grant in progress.
- ptr (3 bits, internal) is the index with highest priority. Priority is circular: ptr, ptr+1, ..., ptr+7, all mod 8.
- IDLE state:
  - If en=1 and req≠0, pick the first i at or after ptr with req[i]=1.
  - At the next edge: gnt=1<<i, sel=i, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - Otherwise remain in IDLE with outputs at zero.
- GRANT state:
  - gnt, sel and gnt_valid hold their values. The select lines never change while gnt_valid=1.
  - Release condition: req[sel]=0, OR (MAX_HOLD≠0 AND hold_cnt==MAX_HOLD).
  - On release, at the next edge: gnt=0, gnt_valid=0, ptr=sel+1 mod 8 (wraps 7→0), hold_cnt=0, state=TURN.
  - sel keeps its last value during TURN.
  - If no release: hold_cnt increments, saturating at 255.
  - A requester that drops its request and hits the limit in the same cycle causes a single release; ptr advances once.
- TURN state:
  - Exactly one cycle with gnt=0.
  - Then state=IDLE; no arbitration happens in TURN.
  - Effective gap between two grants: 1 cycle in TURN, 1 cycle of arbitration in IDLE. With continuous requests, each requester is granted MAX_HOLD cycles out of every MAX_HOLD+2.
- en has no effect in GRANT or TURN. en=0 in IDLE blocks new grants; ptr is unchanged.
- A single requester holding req continuously is re-granted after the turnaround. Fairness comes only from ptr rotation.
- req bits of non-granted requesters may change at any time without effect until arbitration.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid = |gnt.
  - gnt[sel]=1 whenever gnt_valid=1.

Decomposition:
- Shared package rr_arb_pkg:
  - N_REQ=8, SEL_W=3.
  - State encoding IDLE=2'd0, GRANT=2'd1, TURN=2'd2; the code 2'd3 recovers to IDLE.
  - HOLD_W=8.
- Sub-module rr_pick8, purely combinational:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Implemented by rotating req by ptr, applying a fixed priority encoder, then adding ptr mod 8.
  - Instantiated once in rr_mux8_arbiter.

Test Plan:
1. Reset, then req=8'b1010_0000 held with en=1 →
   - 1 cycle later: gnt=8'b0010_0000, sel=5.
   - Drop req[5] after 2 grant cycles → gnt=0 for the TURN cycle.
   - Next: gnt=8'b1000_0000, sel=7 (ptr=6).
2. MAX_HOLD=4, req=8'hFF held →
   - Grants go in the order 0,1,...,7,0, each with gnt_valid high for 4 cycles.
   - Grant starts are 6 cycles apart.
   - ptr wraps 7→0.
3. MAX_HOLD=4, only req[3] held forever →
   - gnt=8'b0000_1000 for 4 cycles, then 2 cycles of zero, repeating.
   - sel stays at 3 throughout.
4. en=0 with req=8'h10 → gnt stays 0 indefinitely. Then:
   - Raise en → grant to index 4.
   - Drop en mid-grant → grant continues until req[4] drops.
5. rst asserted mid-grant of index 6 →
   - Next edge: gnt=0, sel=0, gnt_valid=0.
   - Then with req=8'h81: first grant goes to index 0 (ptr reset to 0).
6. MAX_HOLD=2, req[2] drops in the same cycle that hold_cnt==2, req=8'h0C →
   - One release; ptr=3.
   - Next grant goes to index 3, not 2.
